// File: rtl/hack_ram_arbiter.sv
// Data RAM arbiter: Hack CPU (priority) vs DMA master.
// DMA gets a forced slot after a bounded wait.
module hack_ram_arbiter #(
   parameter int AW       = 15,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 8,
   parameter int RD_LAT   = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   input  logic          dma_req,
   input  logic          dma_wr,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_rvalid,
   output logic          ram_wr,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic [15:0]   stall_cnt
);

   localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT - 1);

   logic [WW-1:0]     wait_cnt;
   logic              force_dma;
   logic              cpu_win;
   logic              dma_win;
   logic              rd_in_v;
   logic              rd_in_o;
   logic [RD_LAT-1:0] pipe_v;
   logic [RD_LAT-1:0] pipe_o;

   // Pick the winner; nothing is granted while reset is held low.
   always_comb begin
      force_dma = (wait_cnt == WAIT_TOP);
      cpu_win   = reset_n & cpu_req & ~(dma_req & force_dma);
      dma_win   = reset_n & dma_req & (~cpu_req | force_dma);
      cpu_stall = reset_n & cpu_req & ~cpu_win;
      dma_gnt   = dma_win;
      rd_in_v   = (cpu_win & ~cpu_wr) | (dma_win & ~dma_wr);
      rd_in_o   = dma_win;
   end

   // Steer the winner onto the RAM port; idle defaults to CPU fields.
   always_comb begin
      ram_wr   = 1'b0;
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
      if (dma_win) begin
         ram_wr   = dma_wr;
         ram_addr = dma_addr;
         ram_din  = dma_wdata;
      end else if (cpu_win) begin
         ram_wr   = cpu_wr;
      end
   end

   // Count consecutive denied DMA cycles up to the forced-slot point.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (dma_req && !dma_win) begin
         if (wait_cnt != WAIT_TOP)
            wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // Track granted reads and their owner until RAM data returns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_v <= '0;
         pipe_o <= '0;
      end else begin
         pipe_v[0] <= rd_in_v;
         pipe_o[0] <= rd_in_o;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_o[i] <= pipe_o[i-1];
         end
      end
   end

   // Saturating count of cycles the CPU spent stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_cnt <= 16'd0;
      else if (cpu_stall && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end

   // Read data fans out to both masters; rvalid marks the owner.
   always_comb begin
      cpu_rdata  = ram_dout;
      dma_rdata  = ram_dout;
      cpu_rvalid = pipe_v[RD_LAT-1] & ~pipe_o[RD_LAT-1];
      dma_rvalid = pipe_v[RD_LAT-1] &  pipe_o[RD_LAT-1];
   end

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter.
// Includes a 1-cycle registered RAM model.
module tb_hack_ram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        cpu_req, cpu_wr;
   logic [14:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_stall, cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        dma_req, dma_wr;
   logic [14:0] dma_addr;
   logic [15:0] dma_wdata;
   logic        dma_gnt, dma_rvalid;
   logic [15:0] dma_rdata;
   logic        ram_wr;
   logic [14:0] ram_addr;
   logic [15:0] ram_din, ram_dout;
   logic [15:0] stall_cnt;

   logic        c1_req, d1_req;
   logic        c1_stall, c1_rvalid;
   logic [15:0] c1_rdata;
   logic        d1_gnt, d1_rvalid;
   logic [15:0] d1_rdata;
   logic        r1_wr;
   logic [14:0] r1_addr;
   logic [15:0] r1_din;
   logic [15:0] r1_dout;
   logic [15:0] s1_cnt;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [0:32767];

   hack_ram_arbiter #(
      .AW(15), .DW(16), .MAX_WAIT(8), .RD_LAT(1)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_wr(dma_wr),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid),
      .ram_wr(ram_wr), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout),
      .stall_cnt(stall_cnt)
   );

   hack_ram_arbiter #(
      .AW(15), .DW(16), .MAX_WAIT(1), .RD_LAT(1)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(c1_req), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(c1_stall), .cpu_rdata(c1_rdata),
      .cpu_rvalid(c1_rvalid),
      .dma_req(d1_req), .dma_wr(dma_wr),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(d1_gnt), .dma_rdata(d1_rdata),
      .dma_rvalid(d1_rvalid),
      .ram_wr(r1_wr), .ram_addr(r1_addr),
      .ram_din(r1_din), .ram_dout(r1_dout),
      .stall_cnt(s1_cnt)
   );

   // Single-port RAM, read-before-write, one cycle read latency.
   always @(posedge clk) begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      cpu_req = 1'b0;
      dma_req = 1'b0;
      c1_req  = 1'b0;
      d1_req  = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      r1_dout   = 16'h0;
      cpu_addr  = 15'd0;
      cpu_wdata = 16'h0;
      dma_addr  = 15'd0;
      dma_wdata = 16'h0;
      idle();
      reset_n = 1'b0;
      cpu_req = 1'b1;
      cpu_wr  = 1'b1;
      dma_req = 1'b1;
      dma_wr  = 1'b1;
      #1;
      smp();
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_gnt", dma_gnt, 1'b0);
      chk("rst_ramwr", ram_wr, 1'b0);
      chk("rst_cnt", stall_cnt, 16'd0);
      chk("rst_rv", {cpu_rvalid, dma_rvalid}, 2'b00);
      tick();
      do_reset();

      // CPU-only write then read
      cpu_req = 1'b1; cpu_wr = 1'b1;
      cpu_addr = 15'd100; cpu_wdata = 16'h1234;
      smp();
      chk("t1_wr_stall", cpu_stall, 1'b0);
      chk("t1_wr_ramwr", ram_wr, 1'b1);
      chk("t1_wr_addr", ram_addr, 15'd100);
      chk("t1_wr_din", ram_din, 16'h1234);
      tick();
      cpu_wr = 1'b0;
      smp();
      chk("t1_rd_stall", cpu_stall, 1'b0);
      chk("t1_rd_ramwr", ram_wr, 1'b0);
      tick();
      idle();
      smp();
      chk("t1_rv", cpu_rvalid, 1'b1);
      chk("t1_data", cpu_rdata, 16'h1234);
      chk("t1_drv", dma_rvalid, 1'b0);
      tick();
      smp();
      chk("t1_rv_pulse", cpu_rvalid, 1'b0);
      tick();

      // DMA-only write then read
      dma_req = 1'b1; dma_wr = 1'b1;
      dma_addr = 15'd3000; dma_wdata = 16'hBEEF;
      smp();
      chk("t2_wr_gnt", dma_gnt, 1'b1);
      chk("t2_wr_addr", ram_addr, 15'd3000);
      chk("t2_wr_ramwr", ram_wr, 1'b1);
      tick();
      dma_wr = 1'b0;
      smp();
      chk("t2_rd_gnt", dma_gnt, 1'b1);
      tick();
      idle();
      smp();
      chk("t2_rv", dma_rvalid, 1'b1);
      chk("t2_data", dma_rdata, 16'hBEEF);
      chk("t2_crv", cpu_rvalid, 1'b0);
      tick();
      smp();
      chk("t2_rv_pulse", dma_rvalid, 1'b0);
      tick();

      // Sustained contention, forced slot every 8th cycle
      do_reset();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'd100;
      dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 15'd3000;
      for (int i = 1; i <= 20; i++) begin
         smp();
         chk($sformatf("t3_gnt_%0d", i), dma_gnt,
             (i == 8 || i == 16));
         chk($sformatf("t3_stall_%0d", i), cpu_stall,
             (i == 8 || i == 16));
         tick();
      end
      idle();
      smp();
      chk("t3_cnt", stall_cnt, 16'd2);
      tick();

      // Interleaved reads returning in grant order
      do_reset();
      cpu_req = 1'b1; cpu_wr = 1'b1;
      cpu_addr = 15'd1; cpu_wdata = 16'd11;
      tick();
      idle();
      dma_req = 1'b1; dma_wr = 1'b1;
      dma_addr = 15'd2; dma_wdata = 16'd22;
      tick();
      idle();
      tick();
      cpu_wr = 1'b0; dma_wr = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         cpu_req = (c <= 9);
         dma_req = (c <= 8);
         smp();
         chk($sformatf("t4_gnt_%0d", c), dma_gnt, (c == 8));
         chk($sformatf("t4_crv_%0d", c), cpu_rvalid,
             ((c >= 2 && c <= 8) || c == 10));
         chk($sformatf("t4_drv_%0d", c), dma_rvalid, (c == 9));
         chk($sformatf("t4_both_%0d", c),
             cpu_rvalid & dma_rvalid, 1'b0);
         if ((c >= 2 && c <= 8) || c == 10)
            chk($sformatf("t4_cd_%0d", c), cpu_rdata, 16'd11);
         if (c == 9)
            chk("t4_dd", dma_rdata, 16'd22);
         tick();
      end
      idle();

      // Reset during an in-flight read
      do_reset();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'd100;
      smp();
      chk("t5_rd_stall", cpu_stall, 1'b0);
      tick();
      reset_n = 1'b0;
      cpu_wr = 1'b1; cpu_wdata = 16'hFFFF;
      smp();
      chk("t5_ramwr", ram_wr, 1'b0);
      chk("t5_stall", cpu_stall, 1'b0);
      chk("t5_rv_in_rst", cpu_rvalid, 1'b0);
      tick();
      reset_n = 1'b1;
      idle();
      cpu_wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk($sformatf("t5_rv_%0d", k),
             {cpu_rvalid, dma_rvalid}, 2'b00);
         chk($sformatf("t5_cnt_%0d", k), stall_cnt, 16'd0);
         tick();
      end

      // MAX_WAIT=1: DMA always wins, counter saturates
      do_reset();
      cpu_wr = 1'b0; dma_wr = 1'b0;
      c1_req = 1'b1; d1_req = 1'b1;
      for (int i = 1; i <= 70000; i++) begin
         smp();
         if (i <= 3) begin
            chk($sformatf("t6_gnt_%0d", i), d1_gnt, 1'b1);
            chk($sformatf("t6_stall_%0d", i), c1_stall, 1'b1);
         end
         if (i == 65535)
            chk("t6_cnt_fffe", s1_cnt, 16'hFFFE);
         if (i == 65536 || i == 70000)
            chk($sformatf("t6_cnt_sat_%0d", i), s1_cnt, 16'hFFFF);
         if (i == 70000)
            chk("t6_gnt_end", d1_gnt, 1'b1);
         tick();
      end
      idle();
      smp();
      chk("t6_cnt_hold", s1_cnt, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
